// File: rtl/divide.sv
`default_nettype none
//==============================================================================
// Module   : divide
// Purpose  : 32-bit sequential restoring divider, signed or unsigned operands.
//            One quotient bit per cycle, MSB first; 32 cycles from the capture
//            edge to the div_end pulse.
//
// Ports    : clk          in   single clock, rising edge
//            reset        in   asynchronous, active-high reset
//            div_begin    in   start request, sampled only in IDLE
//            div_signed   in   1 = two's-complement operands, 0 = unsigned
//            div_op1[31:0]in   dividend
//            div_op2[31:0]in   divisor
//            quotient     out  registered quotient
//            remainder    out  registered remainder (takes the dividend sign)
//            div_end      out  one-cycle completion pulse
//            div_by_zero  out  1 = last completed division had divisor 0
//
// Config   : DIV_BYZERO_FAST_EN - when defined, a zero divisor completes
//            1 cycle after capture instead of running all 32 iterations.
//
// Revision : 1.0 - initial release
//==============================================================================
module divide (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_begin,
    input  logic        div_signed,
    input  logic [31:0] div_op1,
    input  logic [31:0] div_op2,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_end,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [32:0] prem_q,    prem_d;     // partial remainder
    logic [31:0] dvd_q,     dvd_d;      // dividend, becomes quotient as bits shift in
    logic [32:0] dvs_q,     dvs_d;      // magnitude of divisor
    logic        qsign_q,   qsign_d;
    logic        rsign_q,   rsign_d;
    logic        zero_q,    zero_d;     // captured divisor was zero
    logic [31:0] op1_raw_q, op1_raw_d;  // untouched dividend for the zero-divisor result
    logic [31:0] quot_q,    quot_d;
    logic [31:0] rem_q,     rem_d;
    logic        end_q,     end_d;
    logic        dbz_q,     dbz_d;

    // Operand magnitudes; -0x80000000 wraps to 0x80000000, which is the
    // correct magnitude when treated as unsigned.
    logic        w_op1_neg;
    logic        w_op2_neg;
    logic [31:0] w_op1_abs;
    logic [31:0] w_op2_abs;

    assign w_op1_neg = div_signed & div_op1[31];
    assign w_op2_neg = div_signed & div_op2[31];
    assign w_op1_abs = w_op1_neg ? (~div_op1 + 32'd1) : div_op1;
    assign w_op2_abs = w_op2_neg ? (~div_op2 + 32'd1) : div_op2;

    // One restoring iteration. The partial remainder is always below the
    // divisor (<= 2^32), so the shifted value fits in 33 bits and bit 33 of
    // the difference is a clean borrow flag.
    logic [33:0] w_shift;
    logic [33:0] w_diff;
    logic        w_ge;
    logic [32:0] w_prem_nxt;
    logic [31:0] w_dvd_nxt;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_shift    = {prem_q, dvd_q[31]};
    assign w_diff     = w_shift - {1'b0, dvs_q};
    assign w_ge       = ~w_diff[33];
    assign w_prem_nxt = w_ge ? w_diff[32:0] : w_shift[32:0];
    assign w_dvd_nxt  = {dvd_q[30:0], w_ge};
    assign w_q_fix    = qsign_q ? (~w_dvd_nxt + 32'd1) : w_dvd_nxt;
    assign w_r_fix    = rsign_q ? (~w_prem_nxt[31:0] + 32'd1) : w_prem_nxt[31:0];

    // Early completion for a zero divisor. The capture edge still passes
    // through BUSY for one cycle so that div_end rises exactly one edge
    // after capture, the same registered-pulse timing as the full path.
    logic w_fast_zero;
`ifdef DIV_BYZERO_FAST_EN
    assign w_fast_zero = zero_q;
`else
    assign w_fast_zero = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        zero_d    = zero_q;
        op1_raw_d = op1_raw_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        end_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (div_begin) begin
                    dvd_d     = w_op1_abs;
                    dvs_d     = {1'b0, w_op2_abs};
                    qsign_d   = w_op1_neg ^ w_op2_neg;
                    rsign_d   = w_op1_neg;
                    zero_d    = (div_op2 == 32'd0);
                    op1_raw_d = div_op1;
                    prem_d    = 33'd0;
                    cnt_d     = 5'd0;
                    state_d   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                prem_d = w_prem_nxt;
                dvd_d  = w_dvd_nxt;
                cnt_d  = cnt_q + 5'd1;
                if ((cnt_q == 5'd31) || w_fast_zero) begin
                    state_d = ST_DONE;
                    end_d   = 1'b1;
                    if (zero_q) begin
                        // Fixed result regardless of signedness: no sign
                        // correction, remainder is the dividend as given.
                        quot_d = 32'hFFFF_FFFF;
                        rem_d  = op1_raw_q;
                        dbz_d  = 1'b1;
                    end else begin
                        quot_d = w_q_fix;
                        rem_d  = w_r_fix;
                        dbz_d  = 1'b0;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            prem_q    <= 33'd0;
            dvd_q     <= 32'd0;
            dvs_q     <= 33'd0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            zero_q    <= 1'b0;
            op1_raw_q <= 32'd0;
            quot_q    <= 32'd0;
            rem_q     <= 32'd0;
            end_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prem_q    <= prem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            zero_q    <= zero_d;
            op1_raw_q <= op1_raw_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            end_q     <= end_d;
            dbz_q     <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_end     = end_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
